jump_redirect_ctrl: RTL and testbench

Consumer of the registered jal/jalr flags leaving the ID-stage jump flag register. It computes the jump target and link value and issues a single PC redirect to fetch. It then drives the flush that clears the flag register and younger pipeline registers. It stalls fetch while a jalr base register is still unresolved.

---
 rtl/jump_redirect_ctrl_pkg.sv | 16 +
 rtl/jump_redirect_ctrl_if.sv | 28 ++
 rtl/jump_redirect_ctrl_jump_target_calc.sv | 22 ++
 rtl/jump_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_jump_redirect_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared types and constants for the jal/jalr redirect controller.
package jump_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RS1 = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } jr_state_t;

    localparam int FLUSH_CYCLES_MIN = 1;
    localparam int FLUSH_CYCLES_MAX = 15;
    localparam int CNT_W            = 4;
    localparam int LINK_OFFSET      = 4;

endpackage

// File: rtl/jump_redirect_ctrl_if.sv
// ID-stage jump flags/operands in, PC redirect / flush / link controls out.
interface jump_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            jal_in;
    logic            jalr_in;
    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] imm_id;
    logic [XLEN-1:0] rs1_val;
    logic            rs1_ready;
    logic            pc_redirect;
    logic [XLEN-1:0] pc_target;
    logic            flush_ir;
    logic            stall_if;
    logic [XLEN-1:0] link_val;
    logic            link_we;
    logic            misalign_err;

    modport master (
        output jal_in, jalr_in, pc_id, imm_id, rs1_val, rs1_ready,
        input  pc_redirect, pc_target, flush_ir, stall_if, link_val, link_we, misalign_err
    );

    modport slave (
        input  jal_in, jalr_in, pc_id, imm_id, rs1_val, rs1_ready,
        output pc_redirect, pc_target, flush_ir, stall_if, link_val, link_we, misalign_err
    );
endinterface

// File: rtl/jump_redirect_ctrl_jump_target_calc.sv
// Combinational jump target / link computation with jalr bit0 clear and alignment check.
module jump_target_calc
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link,
    output logic            misaligned
);
    logic [XLEN-1:0] sum;

    assign sum        = (is_jalr ? rs1_val : pc_id) + imm_id;
    assign target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    // Bit 0 is always clear for jalr; bit 1 alone decides 4-byte alignment.
    assign misaligned = target[1];
    assign link       = pc_id + XLEN'(LINK_OFFSET);
endmodule

// File: rtl/jump_redirect_ctrl.sv
// Issues one PC redirect per jal/jalr, then flushes; stalls fetch while a jalr base is pending.
//
//   state    | meaning
//   IDLE     | waiting for a jal/jalr flag from the ID flag register
//   WAIT_RS1 | jalr accepted, rs1 not yet forwarded; fetch stalled
//   REDIRECT | pc_redirect/link_we pulse, first flush cycle
//   FLUSH    | remaining flush cycles, down-counter running
module jump_redirect_ctrl
    import jump_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jump_redirect_ctrl_if.slave  bus
);
    localparam int FC = (FLUSH_CYCLES < FLUSH_CYCLES_MIN) ? FLUSH_CYCLES_MIN :
                        (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ? FLUSH_CYCLES_MAX : FLUSH_CYCLES;

    jr_state_t        state;
    logic [CNT_W-1:0] flush_cnt;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    logic             misaligned;
    logic             is_jalr;
    logic             capture;

    logic             pc_redirect_q;
    logic [XLEN-1:0]  pc_target_q;
    logic             flush_ir_q;
    logic [XLEN-1:0]  link_val_q;
    logic             link_we_q;
    logic             misalign_err_q;

    // In WAIT_RS1 the held instruction is the jalr; otherwise jal takes priority.
    assign is_jalr = (state == WAIT_RS1) || !bus.jal_in;
    assign capture = ((state == IDLE) && (bus.jal_in || (bus.jalr_in && bus.rs1_ready))) ||
                     ((state == WAIT_RS1) && bus.rs1_ready);

    jump_target_calc #(.XLEN(XLEN)) u_calc (
        .is_jalr    (is_jalr),
        .pc_id      (bus.pc_id),
        .imm_id     (bus.imm_id),
        .rs1_val    (bus.rs1_val),
        .target     (target),
        .link       (link),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flush_cnt      <= '0;
            pc_redirect_q  <= 1'b0;
            pc_target_q    <= '0;
            flush_ir_q     <= 1'b0;
            link_val_q     <= '0;
            link_we_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            pc_redirect_q  <= 1'b0;
            link_we_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            if (capture) begin
                pc_target_q <= target;
                link_val_q  <= link;
                if (misaligned) begin
                    misalign_err_q <= 1'b1;
                    state          <= IDLE;
                end else begin
                    pc_redirect_q <= 1'b1;
                    link_we_q     <= 1'b1;
                    flush_ir_q    <= 1'b1;
                    state         <= REDIRECT;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.jalr_in) state <= WAIT_RS1;
                    end
                    WAIT_RS1: begin
                        state <= WAIT_RS1;
                    end
                    REDIRECT: begin
                        if (FC > 1) begin
                            state     <= FLUSH;
                            flush_cnt <= CNT_W'(FC - 1);
                        end else begin
                            state      <= IDLE;
                            flush_ir_q <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt <= CNT_W'(1)) begin
                            state      <= IDLE;
                            flush_ir_q <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall_if     = (state == WAIT_RS1);
    assign bus.pc_redirect  = pc_redirect_q;
    assign bus.pc_target    = pc_target_q;
    assign bus.flush_ir     = flush_ir_q;
    assign bus.link_val     = link_val_q;
    assign bus.link_we      = link_we_q;
    assign bus.misalign_err = misalign_err_q;
endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl with FLUSH_CYCLES=1 (d1) and FLUSH_CYCLES=3 (d3).
module tb_jump_redirect_ctrl;
    logic        clk;
    logic        rst_n;
    logic        jal;
    logic        jalr;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    int          n_checks;
    int          n_errors;
    int          redir_cnt;

    jump_redirect_ctrl_if #(.XLEN(32)) bus1 ();
    jump_redirect_ctrl_if #(.XLEN(32)) bus3 ();

    assign bus1.jal_in    = jal;
    assign bus1.jalr_in   = jalr;
    assign bus1.pc_id     = pc;
    assign bus1.imm_id    = imm;
    assign bus1.rs1_val   = rs1;
    assign bus1.rs1_ready = rdy;
    assign bus3.jal_in    = jal;
    assign bus3.jalr_in   = jalr;
    assign bus3.pc_id     = pc;
    assign bus3.imm_id    = imm;
    assign bus3.rs1_val   = rs1;
    assign bus3.rs1_ready = rdy;

    jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        redir_cnt = 0;
        rst_n = 1'b0;
        jal   = 1'b0;
        jalr  = 1'b0;
        rdy   = 1'b0;
        pc    = '0;
        imm   = '0;
        rs1   = '0;

        #2;
        chk("rst_redirect", 32'(bus1.pc_redirect), 0);
        chk("rst_target",   bus1.pc_target, 0);
        chk("rst_flush",    32'(bus1.flush_ir), 0);
        chk("rst_stall",    32'(bus1.stall_if), 0);
        chk("rst_link_we",  32'(bus1.link_we), 0);
        chk("rst_misalign", 32'(bus1.misalign_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);

        // jal, single flush cycle
        pc = 32'h100; imm = 32'h20; jal = 1'b1;
        @(negedge clk);
        chk("jal_redirect", 32'(bus1.pc_redirect), 1);
        chk("jal_target",   bus1.pc_target, 32'h120);
        chk("jal_link",     bus1.link_val, 32'h104);
        chk("jal_link_we",  32'(bus1.link_we), 1);
        chk("jal_flush",    32'(bus1.flush_ir), 1);
        chk("jal_stall",    32'(bus1.stall_if), 0);
        jal = 1'b0;
        @(negedge clk);
        chk("jal_redirect_end", 32'(bus1.pc_redirect), 0);
        chk("jal_flush_end",    32'(bus1.flush_ir), 0);
        chk("jal_link_we_end",  32'(bus1.link_we), 0);
        idle_cycles(4);

        // jalr with rs1 pending for 3 cycles
        pc = 32'h200; imm = 32'h4; rs1 = 32'h2001; jalr = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("jalr_wait_stall",    32'(bus1.stall_if), 1);
            chk("jalr_wait_redirect", 32'(bus1.pc_redirect), 0);
        end
        rdy = 1'b1;
        @(negedge clk);
        chk("jalr_stall_end", 32'(bus1.stall_if), 0);
        chk("jalr_redirect",  32'(bus1.pc_redirect), 1);
        chk("jalr_target",    bus1.pc_target, 32'h2004);
        chk("jalr_link",      bus1.link_val, 32'h204);
        jalr = 1'b0; rdy = 1'b0;
        idle_cycles(4);

        // misaligned jal target
        pc = 32'h100; imm = 32'h2; jal = 1'b1;
        @(negedge clk);
        chk("mis_err",      32'(bus1.misalign_err), 1);
        chk("mis_target",   bus1.pc_target, 32'h102);
        chk("mis_redirect", 32'(bus1.pc_redirect), 0);
        chk("mis_link_we",  32'(bus1.link_we), 0);
        chk("mis_flush",    32'(bus1.flush_ir), 0);
        jal = 1'b0;
        @(negedge clk);
        chk("mis_err_end", 32'(bus1.misalign_err), 0);
        idle_cycles(4);

        // FLUSH_CYCLES=3: jal then jalr for two cycles must be squashed
        pc = 32'h300; imm = 32'h40; jal = 1'b1;
        @(negedge clk);
        jal = 1'b0; jalr = 1'b1; rdy = 1'b1; rs1 = 32'h5000;
        redir_cnt += int'(bus3.pc_redirect);
        chk("fc3_flush1",  32'(bus3.flush_ir), 1);
        chk("fc3_target",  bus3.pc_target, 32'h340);
        @(negedge clk);
        redir_cnt += int'(bus3.pc_redirect);
        chk("fc3_flush2",  32'(bus3.flush_ir), 1);
        chk("fc3_stall2",  32'(bus3.stall_if), 0);
        @(negedge clk);
        redir_cnt += int'(bus3.pc_redirect);
        chk("fc3_flush3",  32'(bus3.flush_ir), 1);
        jalr = 1'b0; rdy = 1'b0;
        @(negedge clk);
        redir_cnt += int'(bus3.pc_redirect);
        chk("fc3_flush_end",  32'(bus3.flush_ir), 0);
        chk("fc3_target_kept", bus3.pc_target, 32'h340);
        chk("fc3_one_redirect", 32'(redir_cnt), 1);
        idle_cycles(4);

        // wrap-around of target and link
        pc = 32'hFFFF_FFFC; imm = 32'h8; jal = 1'b1;
        @(negedge clk);
        chk("wrap_target",   bus1.pc_target, 32'h0000_0004);
        chk("wrap_link",     bus1.link_val, 32'h0000_0000);
        chk("wrap_redirect", 32'(bus1.pc_redirect), 1);
        jal = 1'b0;
        idle_cycles(4);

        // jal and jalr together: jal wins
        pc = 32'h400; imm = 32'h10; rs1 = 32'h8000; jal = 1'b1; jalr = 1'b1; rdy = 1'b1;
        @(negedge clk);
        chk("both_target", bus1.pc_target, 32'h410);
        chk("both_stall",  32'(bus1.stall_if), 0);
        jal = 1'b0; jalr = 1'b0; rdy = 1'b0;
        idle_cycles(4);

        // jalr with rs1 ready immediately, bit0 clear
        pc = 32'h600; imm = 32'h5; rs1 = 32'h1000; jalr = 1'b1; rdy = 1'b1;
        @(negedge clk);
        chk("jalr_now_target",   bus1.pc_target, 32'h1004);
        chk("jalr_now_link",     bus1.link_val, 32'h604);
        chk("jalr_now_redirect", 32'(bus1.pc_redirect), 1);
        jalr = 1'b0; rdy = 1'b0;
        idle_cycles(4);

        // reset during WAIT_RS1
        pc = 32'h700; imm = 32'h0; rs1 = 32'h3000; jalr = 1'b1; rdy = 1'b0;
        idle_cycles(2);
        chk("rstw_pre_stall", 32'(bus1.stall_if), 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_stall",  32'(bus1.stall_if), 0);
        chk("rstw_target", bus1.pc_target, 0);
        chk("rstw_link",   bus1.link_val, 0);
        @(negedge clk);
        rst_n = 1'b1; jalr = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw_no_redirect", 32'(bus1.pc_redirect), 0);
            chk("rstw_no_stall",    32'(bus1.stall_if), 0);
        end
        rdy = 1'b0;
        idle_cycles(2);

        // reset during FLUSH on d3
        pc = 32'h800; imm = 32'h40; jal = 1'b1;
        @(negedge clk);
        jal = 1'b0;
        chk("rstf_redirect", 32'(bus3.pc_redirect), 1);
        @(negedge clk);
        chk("rstf_pre_flush", 32'(bus3.flush_ir), 1);
        rst_n = 1'b0;
        #1;
        chk("rstf_flush",  32'(bus3.flush_ir), 0);
        chk("rstf_target", bus3.pc_target, 0);
        chk("rstf_link",   bus3.link_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstf_no_flush",    32'(bus3.flush_ir), 0);
            chk("rstf_no_redirect", 32'(bus3.pc_redirect), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
